branch_update_queue: RTL and testbench

In-order tracking queue for predicted conditional branches, sitting directly upstream of the 32-entry branch predictor's update port. Fetch allocates an entry per predicted branch, recording the predictor index and the prediction. Execute resolves entries out of order by tag. The queue retires resolved entries in program order, driving exactly one predictor update per branch and flagging mispredictions for front-end redirect.

---
 rtl/branch_update_queue_if.sv | 48 ++++
 rtl/branch_update_queue.sv | 130 +++++++++++++
 tb/tb_branch_update_queue.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/branch_update_queue_if.sv
// rtl/branch_update_queue_if.sv - fetch/execute/predictor-update signal bundle for the branch update queue
interface branch_update_queue_if #(
    parameter int DEPTH = 8,
    parameter int IDX_W = 5
);
    localparam int TAG_W = $clog2(DEPTH);

    // Fetch-side allocation
    logic             alloc_v_i;
    logic [IDX_W-1:0] alloc_idx_i;
    logic             alloc_pred_i;
    logic             alloc_ready_o;
    logic [TAG_W-1:0] alloc_tag_o;

    // Execute-side resolution
    logic             resolve_v_i;
    logic [TAG_W-1:0] resolve_tag_i;
    logic             resolve_taken_i;

    // Predictor update port and redirect flag
    logic             update_o;
    logic [IDX_W-1:0] update_addr_o;
    logic             br_taken_o;
    logic             mispredict_o;

    // Occupancy status
    logic [TAG_W:0]   count_o;
    logic             empty_o;
    logic             full_o;

    // Driven by fetch/execute; observes the queue
    modport master (
        output alloc_v_i, alloc_idx_i, alloc_pred_i,
        output resolve_v_i, resolve_tag_i, resolve_taken_i,
        input  alloc_ready_o, alloc_tag_o,
        input  update_o, update_addr_o, br_taken_o, mispredict_o,
        input  count_o, empty_o, full_o
    );

    // The queue itself
    modport slave (
        input  alloc_v_i, alloc_idx_i, alloc_pred_i,
        input  resolve_v_i, resolve_tag_i, resolve_taken_i,
        output alloc_ready_o, alloc_tag_o,
        output update_o, update_addr_o, br_taken_o, mispredict_o,
        output count_o, empty_o, full_o
    );
endinterface

// File: rtl/branch_update_queue.sv
// rtl/branch_update_queue.sv - in-order retire queue feeding branch predictor updates with mispredict flush
module branch_update_queue #(
    parameter int DEPTH = 8,
    parameter int IDX_W = 5
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    branch_update_queue_if.slave  bus
);
    localparam int TAG_W = $clog2(DEPTH);

    // Per-slot state; slot number doubles as the branch tag
    logic [DEPTH-1:0] entValid;
    logic [DEPTH-1:0] entResolved;
    logic [DEPTH-1:0] entPred;
    logic [DEPTH-1:0] entTaken;
    logic [IDX_W-1:0] entIdx [DEPTH];

    // Pointers carry an extra wrap bit so full and empty are distinguishable
    logic [TAG_W:0]   headPtr;
    logic [TAG_W:0]   tailPtr;
    logic [TAG_W:0]   headNext;
    logic [TAG_W:0]   tailNext;
    logic [TAG_W:0]   countNext;

    logic [TAG_W-1:0] headTag;
    logic [TAG_W-1:0] tailTag;
    logic [TAG_W-1:0] resolveTag;

    logic             headRetire;
    logic             flushNow;
    logic             allocReady;
    logic             allocFire;
    logic             resolveHit;

    assign headTag    = headPtr[TAG_W-1:0];
    assign tailTag    = tailPtr[TAG_W-1:0];
    assign resolveTag = bus.resolve_tag_i;

    // The head leaves once its outcome is known; a wrong guess there kills everything younger
    assign headRetire = entValid[headTag] && entResolved[headTag];
    assign flushNow   = headRetire && (entTaken[headTag] != entPred[headTag]);

    // full_o is registered so a same-cycle retire cannot free the slot for this cycle's allocation
    assign allocReady = !bus.full_o && !flushNow;
    assign allocFire  = bus.alloc_v_i && allocReady;

    // Only the first outcome for a live entry counts; the tail slot is never valid
    // before its allocation edge, so a same-cycle resolve to it falls through
    assign resolveHit = bus.resolve_v_i && entValid[resolveTag] && !entResolved[resolveTag];

    assign bus.alloc_ready_o = allocReady;
    assign bus.alloc_tag_o   = tailTag;

    // Next pointer and occupancy values; a flush collapses the queue onto the advanced head
    always_comb begin
        headNext  = headPtr + (TAG_W+1)'(headRetire);
        tailNext  = tailPtr + (TAG_W+1)'(allocFire);
        countNext = bus.count_o + (TAG_W+1)'(allocFire) - (TAG_W+1)'(headRetire);
        if (flushNow) begin
            tailNext  = headNext;
            countNext = '0;
        end
    end

    // Entry storage: allocate at tail, record outcomes by tag, clear at head or on flush
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            entValid    <= '0;
            entResolved <= '0;
            entPred     <= '0;
            entTaken    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entIdx[i] <= '0;
            end
        end else if (flushNow) begin
            // Resolves landing in the same cycle are discarded along with their entries
            entValid <= '0;
        end else begin
            if (headRetire) begin
                entValid[headTag] <= 1'b0;
            end
            if (resolveHit) begin
                entResolved[resolveTag] <= 1'b1;
                entTaken[resolveTag]    <= bus.resolve_taken_i;
            end
            if (allocFire) begin
                entValid[tailTag]    <= 1'b1;
                entResolved[tailTag] <= 1'b0;
                entPred[tailTag]     <= bus.alloc_pred_i;
                entIdx[tailTag]      <= bus.alloc_idx_i;
            end
        end
    end

    // Pointers and registered occupancy flags
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            headPtr     <= '0;
            tailPtr     <= '0;
            bus.count_o <= '0;
            bus.empty_o <= 1'b1;
            bus.full_o  <= 1'b0;
        end else begin
            headPtr     <= headNext;
            tailPtr     <= tailNext;
            bus.count_o <= countNext;
            bus.empty_o <= (headNext == tailNext);
            bus.full_o  <= (headNext[TAG_W] != tailNext[TAG_W]) &&
                           (headNext[TAG_W-1:0] == tailNext[TAG_W-1:0]);
        end
    end

    // Predictor update port: pulse per retirement, address and outcome held between pulses
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            bus.update_o      <= 1'b0;
            bus.mispredict_o  <= 1'b0;
            bus.update_addr_o <= '0;
            bus.br_taken_o    <= 1'b0;
        end else begin
            bus.update_o     <= headRetire;
            bus.mispredict_o <= flushNow;
            if (headRetire) begin
                bus.update_addr_o <= entIdx[headTag];
                bus.br_taken_o    <= entTaken[headTag];
            end
        end
    end
endmodule

// File: tb/tb_branch_update_queue.sv
// tb/tb_branch_update_queue.sv - vector-table bench for branch_update_queue
module tb_branch_update_queue;
    logic clk_i = 1'b0;
    logic reset_i;

    always #5 clk_i = ~clk_i;

    branch_update_queue_if #(.DEPTH(8), .IDX_W(5)) bus();

    branch_update_queue #(.DEPTH(8), .IDX_W(5)) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .bus     (bus)
    );

    typedef struct {
        logic       av;
        logic [4:0] aidx;
        logic       apred;
        logic       rv;
        logic [2:0] rtag;
        logic       rtaken;
        logic       eReady;
        logic [2:0] eTag;
        logic       eUpd;
        logic [4:0] eAddr;
        logic       eBrt;
        logic       eMis;
        logic [3:0] eCnt;
        logic       eEmp;
        logic       eFull;
    } vec_t;

    vec_t vecs[$];
    int checks   = 0;
    int failures = 0;

    function automatic vec_t mk(input int av, input int aidx, input int apred,
                                input int rv, input int rtag, input int rtaken,
                                input int rdy, input int tag, input int upd,
                                input int addr, input int brt, input int mis,
                                input int cnt, input int emp, input int full);
        vec_t r;
        r.av     = 1'(av);
        r.aidx   = 5'(aidx);
        r.apred  = 1'(apred);
        r.rv     = 1'(rv);
        r.rtag   = 3'(rtag);
        r.rtaken = 1'(rtaken);
        r.eReady = 1'(rdy);
        r.eTag   = 3'(tag);
        r.eUpd   = 1'(upd);
        r.eAddr  = 5'(addr);
        r.eBrt   = 1'(brt);
        r.eMis   = 1'(mis);
        r.eCnt   = 4'(cnt);
        r.eEmp   = 1'(emp);
        r.eFull  = 1'(full);
        return r;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic drive(input int av, input int aidx, input int apred,
                         input int rv, input int rtag, input int rtaken);
        bus.alloc_v_i       = 1'(av);
        bus.alloc_idx_i     = 5'(aidx);
        bus.alloc_pred_i    = 1'(apred);
        bus.resolve_v_i     = 1'(rv);
        bus.resolve_tag_i   = 3'(rtag);
        bus.resolve_taken_i = 1'(rtaken);
    endtask

    task automatic checkAll(input string nm, input vec_t r);
        check({nm, ".ready"}, int'(bus.alloc_ready_o), int'(r.eReady));
        check({nm, ".tag"},   int'(bus.alloc_tag_o),   int'(r.eTag));
        check({nm, ".upd"},   int'(bus.update_o),      int'(r.eUpd));
        check({nm, ".mis"},   int'(bus.mispredict_o),  int'(r.eMis));
        check({nm, ".cnt"},   int'(bus.count_o),       int'(r.eCnt));
        check({nm, ".empty"}, int'(bus.empty_o),       int'(r.eEmp));
        check({nm, ".full"},  int'(bus.full_o),        int'(r.eFull));
        if (r.eUpd) begin
            check({nm, ".addr"}, int'(bus.update_addr_o), int'(r.eAddr));
            check({nm, ".brt"},  int'(bus.br_taken_o),    int'(r.eBrt));
        end
    endtask

    initial begin
        // Single branch, resolve latency 2 to update
        vecs.push_back(mk(1, 4,0, 0,0,0, 1,0,0, 0,0,0, 0,1,0));
        vecs.push_back(mk(0, 0,0, 1,0,0, 1,1,0, 0,0,0, 1,0,0));
        vecs.push_back(mk(0, 0,0, 0,0,0, 1,1,0, 0,0,0, 1,0,0));
        vecs.push_back(mk(0, 0,0, 0,0,0, 1,1,1, 4,0,0, 0,1,0));
        // Out-of-order resolve, in-order back-to-back retirement
        vecs.push_back(mk(1,15,1, 0,0,0, 1,1,0, 0,0,0, 0,1,0));
        vecs.push_back(mk(1,27,0, 0,0,0, 1,2,0, 0,0,0, 1,0,0));
        vecs.push_back(mk(1, 6,1, 0,0,0, 1,3,0, 0,0,0, 2,0,0));
        vecs.push_back(mk(0, 0,0, 1,3,1, 1,4,0, 0,0,0, 3,0,0));
        vecs.push_back(mk(0, 0,0, 1,2,0, 1,4,0, 0,0,0, 3,0,0));
        vecs.push_back(mk(0, 0,0, 1,1,1, 1,4,0, 0,0,0, 3,0,0));
        vecs.push_back(mk(0, 0,0, 0,0,0, 1,4,0, 0,0,0, 3,0,0));
        vecs.push_back(mk(0, 0,0, 0,0,0, 1,4,1,15,1,0, 2,0,0));
        vecs.push_back(mk(0, 0,0, 0,0,0, 1,4,1,27,0,0, 1,0,0));
        vecs.push_back(mk(0, 0,0, 0,0,0, 1,4,1, 6,1,0, 0,1,0));
        vecs.push_back(mk(0, 0,0, 0,0,0, 1,4,0, 0,0,0, 0,1,0));
        // Fill all 8 slots, tags wrap through 7 back to 0
        for (int i = 0; i < 8; i++) begin
            vecs.push_back(mk(1, 8+i,0, 0,0,0, 1,(4+i)%8,0, 0,0,0, i,(i==0)?1:0,0));
        end
        // Ninth request dropped; retire while full still rejects, next cycle accepts
        vecs.push_back(mk(1,30,0, 0,0,0, 0,4,0, 0,0,0, 8,0,1));
        vecs.push_back(mk(1,30,1, 1,4,0, 0,4,0, 0,0,0, 8,0,1));
        vecs.push_back(mk(1,30,1, 0,0,0, 0,4,0, 0,0,0, 8,0,1));
        vecs.push_back(mk(1,30,1, 0,0,0, 1,4,1, 8,0,0, 7,0,0));
        vecs.push_back(mk(0, 0,0, 0,0,0, 0,5,0, 0,0,0, 8,0,1));
        // Mispredict at head of a full queue; same-cycle and late resolves discarded
        vecs.push_back(mk(0, 0,0, 1,5,1, 0,5,0, 0,0,0, 8,0,1));
        vecs.push_back(mk(1, 1,0, 1,6,0, 0,5,0, 0,0,0, 8,0,1));
        vecs.push_back(mk(0, 0,0, 1,7,0, 1,6,1, 9,1,1, 0,1,0));
        vecs.push_back(mk(0, 0,0, 1,6,0, 1,6,0, 0,0,0, 0,1,0));
        vecs.push_back(mk(0, 0,0, 0,0,0, 1,6,0, 0,0,0, 0,1,0));
        // Mispredict with 3 younger entries; allocation blocked in the flush cycle
        vecs.push_back(mk(1,23,0, 0,0,0, 1,6,0, 0,0,0, 0,1,0));
        vecs.push_back(mk(1, 1,1, 0,0,0, 1,7,0, 0,0,0, 1,0,0));
        vecs.push_back(mk(1, 2,1, 0,0,0, 1,0,0, 0,0,0, 2,0,0));
        vecs.push_back(mk(1, 3,0, 0,0,0, 1,1,0, 0,0,0, 3,0,0));
        vecs.push_back(mk(0, 0,0, 1,6,1, 1,2,0, 0,0,0, 4,0,0));
        vecs.push_back(mk(1,17,0, 1,7,1, 0,2,0, 0,0,0, 4,0,0));
        vecs.push_back(mk(0, 0,0, 1,7,1, 1,7,1,23,1,1, 0,1,0));
        vecs.push_back(mk(0, 0,0, 1,0,1, 1,7,0, 0,0,0, 0,1,0));
        vecs.push_back(mk(0, 0,0, 0,0,0, 1,7,0, 0,0,0, 0,1,0));
        // Duplicate resolve keeps the first outcome (taken, a mispredict)
        vecs.push_back(mk(1,12,1, 0,0,0, 1,7,0, 0,0,0, 0,1,0));
        vecs.push_back(mk(1,13,0, 0,0,0, 1,0,0, 0,0,0, 1,0,0));
        vecs.push_back(mk(0, 0,0, 1,0,1, 1,1,0, 0,0,0, 2,0,0));
        vecs.push_back(mk(0, 0,0, 1,0,0, 1,1,0, 0,0,0, 2,0,0));
        vecs.push_back(mk(0, 0,0, 1,7,1, 1,1,0, 0,0,0, 2,0,0));
        vecs.push_back(mk(0, 0,0, 0,0,0, 1,1,0, 0,0,0, 2,0,0));
        vecs.push_back(mk(0, 0,0, 0,0,0, 0,1,1,12,1,0, 1,0,0));
        vecs.push_back(mk(0, 0,0, 0,0,0, 1,1,1,13,1,1, 0,1,0));
        vecs.push_back(mk(0, 0,0, 0,0,0, 1,1,0, 0,0,0, 0,1,0));

        reset_i = 1'b1;
        drive(0,0,0, 0,0,0);
        #2 reset_i = 1'b0;
        @(negedge clk_i);
        #1;
        check("reset.empty", int'(bus.empty_o),       1);
        check("reset.cnt",   int'(bus.count_o),       0);
        check("reset.full",  int'(bus.full_o),        0);
        check("reset.ready", int'(bus.alloc_ready_o), 1);
        check("reset.tag",   int'(bus.alloc_tag_o),   0);
        check("reset.upd",   int'(bus.update_o),      0);
        check("reset.mis",   int'(bus.mispredict_o),  0);
        check("reset.addr",  int'(bus.update_addr_o), 0);
        check("reset.brt",   int'(bus.br_taken_o),    0);
        @(negedge clk_i);
        reset_i = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk_i);
            drive(vecs[i].av, vecs[i].aidx, vecs[i].apred,
                  vecs[i].rv, vecs[i].rtag, vecs[i].rtaken);
            #1;
            checkAll($sformatf("row%0d", i), vecs[i]);
        end

        // Mid-operation reset: 5 in flight, head resolved and about to retire
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            drive(1, 16+i, 0, 0, 0, 0);
            #1;
            check($sformatf("fill%0d.tag", i), int'(bus.alloc_tag_o), i + 1);
        end
        @(negedge clk_i);
        drive(0,0,0, 1,1,0);
        #1;
        check("fill.cnt", int'(bus.count_o), 5);
        @(negedge clk_i);
        drive(0,0,0, 0,0,0);
        reset_i = 1'b0;
        #1;
        check("midrst.cnt",   int'(bus.count_o),       0);
        check("midrst.empty", int'(bus.empty_o),       1);
        check("midrst.tag",   int'(bus.alloc_tag_o),   0);
        check("midrst.upd",   int'(bus.update_o),      0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_i);
            #1;
            check($sformatf("midrst.hold%0d.upd", i), int'(bus.update_o), 0);
        end
        reset_i = 1'b1;
        @(negedge clk_i);
        #1;
        check("postrst.upd", int'(bus.update_o), 0);
        check("postrst.cnt", int'(bus.count_o),  0);

        // Resolve to the tail in its allocation cycle is ignored; later resolve wins
        @(negedge clk_i);
        drive(1,21,1, 1,0,0);
        #1;
        check("tailres.tag", int'(bus.alloc_tag_o), 0);
        @(negedge clk_i);
        drive(0,0,0, 1,0,1);
        #1;
        check("tailres.cnt", int'(bus.count_o), 1);
        check("tailres.upd0", int'(bus.update_o), 0);
        @(negedge clk_i);
        drive(0,0,0, 0,0,0);
        #1;
        check("tailres.upd1", int'(bus.update_o), 0);
        @(negedge clk_i);
        #1;
        check("tailres.upd2",  int'(bus.update_o),      1);
        check("tailres.addr",  int'(bus.update_addr_o), 21);
        check("tailres.brt",   int'(bus.br_taken_o),    1);
        check("tailres.mis",   int'(bus.mispredict_o),  0);
        check("tailres.empty", int'(bus.empty_o),       1);
        @(negedge clk_i);
        #1;
        check("tailres.held.addr", int'(bus.update_addr_o), 21);
        check("tailres.held.upd",  int'(bus.update_o),      0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
